ram_1w1r_clr: RTL and testbench

//  Parametrised 1-write/1-read synchronous RAM with registered read, read-valid strobe and a

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_core_1w1r.sv | 62 ++++++
 rtl/ram_1w1r_clr.sv | 84 ++++++++
 tb/tb_ram_1w1r_clr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default geometry for the 1W1R clearable RAM and the solver datapath.
package ram_pkg;

    typedef enum logic {
        StClear,
        StIdle
    } ram_state_e;

    localparam int unsigned RamDw    = 28;
    localparam int unsigned RamAw    = 8;
    localparam int unsigned RamDepth = 256;

endpackage

// File: rtl/ram_core_1w1r.sv
// Bare DEPTHxDW array with one write port and a registered read port (optional write bypass).
module ram_core_1w1r #(
    parameter int unsigned DW     = 28,
    parameter int unsigned AW     = 8,
    parameter int unsigned DEPTH  = 256,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o
);

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q;
    logic          wr_ok, rd_in_range;

    assign wr_ok       = we_i && ({1'b0, waddr_i} < DepthW);
    assign rd_in_range = {1'b0, raddr_i} < DepthW;

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_in_range) begin
            if (BYPASS && wr_ok && (waddr_i == raddr_i)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[raddr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/ram_1w1r_clr.sv
// 1W1R synchronous RAM with a clear engine that writes INIT_VAL to every word after reset or on
// request; user traffic is ignored while busy_o is high.
module ram_1w1r_clr
    import ram_pkg::*;
#(
    parameter int unsigned   DW       = RamDw,
    parameter int unsigned   AW       = RamAw,
    parameter int unsigned   DEPTH    = RamDepth,
    parameter logic [DW-1:0] INIT_VAL = '0,
    parameter bit            BYPASS   = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    input  logic          clr_req_i,
    output logic          busy_o
);

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    ram_state_e    state_q;
    logic [AW-1:0] clr_ptr_q;

    logic          clearing, accept;
    logic          core_we, core_re;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LastPtr) begin
                        state_q   <= StIdle;
                        clr_ptr_q <= '0;
                    end
                end
                StIdle: begin
                    if (clr_req_i) begin
                        state_q   <= StClear;
                        clr_ptr_q <= '0;
                    end
                end
            endcase
        end
    end

    // The cycle that accepts a clear request also drops that cycle's user access.
    assign clearing   = (state_q == StClear);
    assign accept     = (state_q == StIdle) && !clr_req_i;
    assign core_we    = clearing || (accept && wr_en_i);
    assign core_re    = accept && rd_en_i;
    assign core_waddr = clearing ? clr_ptr_q : wr_addr_i;
    assign core_wdata = clearing ? INIT_VAL : wr_data_i;
    assign busy_o     = clearing;

    ram_core_1w1r #(
        .DW     (DW),
        .AW     (AW),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (core_we),
        .waddr_i  (core_waddr),
        .wdata_i  (core_wdata),
        .re_i     (core_re),
        .raddr_i  (rd_addr_i),
        .rdata_o  (rd_data_o),
        .rvalid_o (rd_valid_o)
    );

endmodule

// File: tb/tb_ram_1w1r_clr.sv
// Bench: two instances (256 words with bypass, 200 words without) driven in lockstep and
// compared every cycle against a behavioural memory model, plus literal spot checks.
module tb_ram_1w1r_clr;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, rd_en, clr_req;
    logic [7:0]  wr_addr, rd_addr;
    logic [27:0] wr_data;
    logic [27:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_1w1r_clr dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_a),
        .rd_valid_o (rd_valid_a),
        .clr_req_i  (clr_req),
        .busy_o     (busy_a)
    );

    ram_1w1r_clr #(
        .DEPTH  (200),
        .BYPASS (1'b0)
    ) dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_b),
        .rd_valid_o (rd_valid_b),
        .clr_req_i  (clr_req),
        .busy_o     (busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: a memory, a count of clear cycles still to run, expected outputs.
    int          depth [2] = '{256, 200};
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [27:0] mm    [2][256];
    int          clr_left [2];
    logic [27:0] exp_rd  [2];
    logic        exp_rdv [2];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                clr_left[i] = depth[i];
                exp_rd[i]   = '0;
                exp_rdv[i]  = 1'b0;
                model_ok    = 1'b1;
            end else if (model_ok) begin
                if (clr_left[i] > 0) begin
                    mm[i][depth[i] - clr_left[i]] = '0;
                    clr_left[i]--;
                    exp_rdv[i] = 1'b0;
                end else if (clr_req) begin
                    clr_left[i] = depth[i];
                    exp_rdv[i]  = 1'b0;
                end else begin
                    exp_rdv[i] = rd_en;
                    if (rd_en) begin
                        if (int'(rd_addr) >= depth[i]) exp_rd[i] = '0;
                        else if (byp[i] && wr_en && wr_addr == rd_addr) exp_rd[i] = wr_data;
                        else exp_rd[i] = mm[i][rd_addr];
                    end
                    if (wr_en && int'(wr_addr) < depth[i]) mm[i][wr_addr] = wr_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy_a", 32'(busy_a), 32'(clr_left[0] > 0));
            chk("busy_b", 32'(busy_b), 32'(clr_left[1] > 0));
            chk("rd_valid_a", 32'(rd_valid_a), 32'(exp_rdv[0]));
            chk("rd_valid_b", 32'(rd_valid_b), 32'(exp_rdv[1]));
            chk("rd_data_a", 32'(rd_data_a), 32'(exp_rd[0]));
            chk("rd_data_b", 32'(rd_data_b), 32'(exp_rd[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic count_busy(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
        end
        tick();
    endtask

    task automatic rd1(input logic [7:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    int ca, cb;

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (2) tick();

        // 1: reset, clear duration, everything reads zero
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_rd_data_a", 32'(rd_data_a), 32'd0);
        count_busy(ca, cb);
        chk("clr_cycles_a", 32'(ca), 32'd256);
        chk("clr_cycles_b", 32'(cb), 32'd200);
        for (int a = 0; a < 256; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            tick();
        end
        chk("rd255_a", 32'(rd_data_a), 32'd0);
        chk("rd255_valid_a", 32'(rd_valid_a), 32'd1);
        rd_en = 1'b0;
        tick();

        // 2: write then read
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 28'hABCDEF1;
        tick();
        wr_en = 1'b0;
        rd1(8'h05);
        chk("wr_rd_a", 32'(rd_data_a), 32'h0ABCDEF1);
        chk("wr_rd_valid_a", 32'(rd_valid_a), 32'd1);
        tick();
        chk("valid_pulse_a", 32'(rd_valid_a), 32'd0);
        chk("hold_a", 32'(rd_data_a), 32'h0ABCDEF1);

        // 3: same-address write + read
        wr_en = 1'b1; wr_addr = 8'h10; wr_data = 28'h1111111;
        tick();
        wr_data = 28'h2222222; rd_en = 1'b1; rd_addr = 8'h10;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("bypass1_a", 32'(rd_data_a), 32'h02222222);
        chk("bypass0_b", 32'(rd_data_b), 32'h01111111);
        rd1(8'h10);
        chk("after_bypass_b", 32'(rd_data_b), 32'h02222222);

        // 4: clear request with a write and read during the clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_a", 32'(busy_a), 32'd1);
        repeat (2) tick();
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 28'h3333333; rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("clr_no_valid_a", 32'(rd_valid_a), 32'd0);
        count_busy(ca, cb);
        chk("clr2_cycles_a", 32'(ca), 32'd253);
        rd1(8'h05);
        chk("cleared05_a", 32'(rd_data_a), 32'd0);
        rd1(8'h10);
        chk("cleared10_b", 32'(rd_data_b), 32'd0);

        // 5: clr_req ignored mid-clear, reset restarts the clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (49) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (49) tick();
        chk("mid_clear_busy_a", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy(ca, cb);
        chk("restart_cycles_a", 32'(ca), 32'd256);
        chk("restart_cycles_b", 32'(cb), 32'd200);

        // 6: out-of-range address on the 200-word instance
        wr_en = 1'b1; wr_addr = 8'd250; wr_data = 28'h0F0F0F0;
        tick();
        wr_en = 1'b0;
        rd1(8'd250);
        chk("oor_rd_b", 32'(rd_data_b), 32'd0);
        chk("oor_valid_b", 32'(rd_valid_b), 32'd1);
        chk("inrange_rd_a", 32'(rd_data_a), 32'h00F0F0F0);
        wr_en = 1'b1; wr_addr = 8'd199; wr_data = 28'h7654321;
        tick();
        wr_en = 1'b0;
        rd1(8'd199);
        chk("last_word_b", 32'(rd_data_b), 32'h07654321);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
